// File: rtl/rc4_ksa_engine.sv
`default_nettype none
// ============================================================================
// Module   : rc4_ksa_engine
// Brief    : RC4 key-scheduling engine driving a single-port synchronous S-box RAM.
// Revision : 1.0
// ============================================================================
module rc4_ksa_engine #(
    parameter int W         = 8,
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   commenco,
    input  logic                   init_en,
    input  logic [W*KEY_BYTES-1:0] secret_key,
    input  logic [W-1:0]           q,
    output logic [W-1:0]           address,
    output logic [W-1:0]           data,
    output logic                   wen,
    output logic                   busy,
    output logic                   finito
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);
    localparam logic [W-1:0]  I_LAST = '1;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_FILL = 4'd1;
    localparam logic [3:0] ST_RD_I = 4'd2;
    localparam logic [3:0] ST_LD_I = 4'd3;
    localparam logic [3:0] ST_RD_J = 4'd4;
    localparam logic [3:0] ST_LD_J = 4'd5;
    localparam logic [3:0] ST_WR_I = 4'd6;
    localparam logic [3:0] ST_WR_J = 4'd7;
    localparam logic [3:0] ST_DONE = 4'd8;

    logic [3:0]             state_q, state_d;
    logic [W-1:0]           i_q, i_d;
    logic [W-1:0]           j_q, j_d;
    logic [KW-1:0]          k_q, k_d;
    logic [W-1:0]           si_q, si_d;
    logic [W-1:0]           sj_q, sj_d;
    logic [W*KEY_BYTES-1:0] key_q, key_d;
    logic [W-1:0]           keybyte;

    // Key byte 0 sits in the most-significant W bits of the latched key.
    always_comb begin
        keybyte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (k_q == KW'(b)) begin
                keybyte = key_q[W*(KEY_BYTES-b)-1 -: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        key_d   = key_q;
        case (state_q)
            ST_IDLE: begin
                if (commenco) begin
                    key_d   = secret_key;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = init_en ? ST_FILL : ST_RD_I;
                end
            end
            ST_FILL: begin
                i_d = i_q + 1'b1;
                if (i_q == I_LAST) begin
                    state_d = ST_RD_I;
                end
            end
            ST_RD_I: state_d = ST_LD_I;
            ST_LD_I: begin
                si_d    = q;
                j_d     = j_q + q + keybyte;
                state_d = ST_RD_J;
            end
            ST_RD_J: state_d = ST_LD_J;
            ST_LD_J: begin
                sj_d    = q;
                state_d = ST_WR_I;
            end
            ST_WR_I: state_d = ST_WR_J;
            ST_WR_J: begin
                k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
                if (i_q == I_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = ST_RD_I;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
        end
    end

    // RAM-side outputs are decoded from state and registers only; q never reaches them directly.
    always_comb begin
        address = '0;
        data    = '0;
        wen     = 1'b0;
        finito  = 1'b0;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_FILL: begin
                address = i_q;
                data    = i_q;
                wen     = 1'b1;
            end
            ST_RD_I, ST_LD_I: address = i_q;
            ST_RD_J, ST_LD_J: address = j_q;
            ST_WR_I: begin
                address = i_q;
                data    = sj_q;
                wen     = 1'b1;
            end
            ST_WR_J: begin
                address = j_q;
                data    = si_q;
                wen     = 1'b1;
            end
            ST_DONE: finito = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rc4_ksa_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc4_ksa_engine
// Brief    : Scoreboard bench for rc4_ksa_engine (W=8/KEY_BYTES=3 and W=4/KEY_BYTES=2).
// Revision : 1.0
// ============================================================================
module tb_rc4_ksa_engine;

    localparam int N8 = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, commenco, init_en, preload;
    logic [23:0] key;
    logic [7:0]  q8, addr8, data8;
    logic        wen8, busy8, fin8;

    logic        commenco4, init4;
    logic [7:0]  key4;
    logic [3:0]  q4, addr4, data4;
    logic        wen4, busy4, fin4;

    rc4_ksa_engine #(.W(8), .KEY_BYTES(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .commenco(commenco), .init_en(init_en),
        .secret_key(key), .q(q8), .address(addr8), .data(data8),
        .wen(wen8), .busy(busy8), .finito(fin8)
    );

    rc4_ksa_engine #(.W(4), .KEY_BYTES(2)) u_small (
        .clk(clk), .rst_n(rst_n), .commenco(commenco4), .init_en(init4),
        .secret_key(key4), .q(q4), .address(addr4), .data(data4),
        .wen(wen4), .busy(busy4), .finito(fin4)
    );

    logic [7:0] mem8 [N8];
    logic [3:0] mem4 [16];

    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < N8; a++) mem8[a] <= 8'(a);
        end else if (wen8) begin
            mem8[addr8] <= data8;
        end
        q8 <= mem8[addr8];
        if (wen4) mem4[addr4] <= data4;
        q4 <= mem4[addr4];
    end

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t        expq [$];
    logic [7:0] model8 [N8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Software KSA from an identity S-box; pushes the expected write trace.
    task automatic build8(input bit init, input logic [23:0] k);
        logic [7:0] s [N8];
        logic [7:0] j, si, sj, kb;
        wr_t e;
        expq.delete();
        for (int i = 0; i < N8; i++) begin
            s[i] = 8'(i);
            if (init) begin
                e.a = 8'(i); e.d = 8'(i);
                expq.push_back(e);
            end
        end
        j = 8'h00;
        for (int i = 0; i < N8; i++) begin
            kb = k[8*(3-(i%3))-1 -: 8];
            si = s[i];
            j  = j + si + kb;
            sj = s[j];
            e.a = 8'(i); e.d = sj; expq.push_back(e);
            e.a = j;     e.d = si; expq.push_back(e);
            s[i] = sj;
            s[j] = si;
        end
        for (int i = 0; i < N8; i++) model8[i] = s[i];
    endtask

    task automatic run8(input bit init, input logic [23:0] k, input int hold_at,
                        input int rst_at, input bit chain);
        int  idx, lim, m;
        bit  seen;
        wr_t e;
        lim = init ? 7*N8 : 6*N8;
        build8(init, k);
        commenco = 1'b1; init_en = init; key = k;
        @(negedge clk);
        commenco = 1'b0;
        idx = 0; seen = 1'b0;
        while (idx <= lim + 4) begin
            if (idx == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_address", addr8, 0);
                check("rst_data", data8, 0);
                check("rst_wen", wen8, 0);
                check("rst_busy", busy8, 0);
                check("rst_finito", fin8, 0);
                @(negedge clk);
                rst_n = 1'b1;
                expq.delete();
                return;
            end
            check("busy_run", busy8, 1);
            if (init && idx == 0) check("first_write", {wen8, addr8, data8}, {1'b1, 8'h00, 8'h00});
            if (wen8) begin
                check("wr_expected", 32'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("wr_addr_data", {addr8, data8}, e);
                end
            end
            if (idx == hold_at)      commenco = 1'b1;
            if (idx == hold_at + 10) commenco = 1'b0;
            if (fin8) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            idx++;
        end
        check("finito_index", seen ? idx : -1, lim);
        check("done_wen", wen8, 0);
        if (chain) commenco = 1'b1;
        @(negedge clk);
        check("busy_fall", busy8, 0);
        check("finito_pulse", fin8, 0);
        check("wr_left", expq.size(), 0);
        m = 0;
        for (int i = 0; i < N8; i++) if (mem8[i] !== model8[i]) m++;
        check("ram_final", m, 0);
    endtask

    task automatic run4(input logic [7:0] k);
        logic [3:0] s [16];
        logic [3:0] j, t, kb;
        int idx, m;
        bit seen;
        for (int i = 0; i < 16; i++) s[i] = 4'(i);
        j = 4'h0;
        for (int i = 0; i < 16; i++) begin
            kb = (i % 2 == 0) ? k[7:4] : k[3:0];
            j  = j + s[i] + kb;
            t  = s[i]; s[i] = s[j]; s[j] = t;
        end
        commenco4 = 1'b1; init4 = 1'b1; key4 = k;
        @(negedge clk);
        commenco4 = 1'b0;
        idx = 0; seen = 1'b0;
        while (idx <= 116) begin
            if (fin4) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            idx++;
        end
        check("small_finito_index", seen ? idx : -1, 112);
        @(negedge clk);
        check("small_busy_fall", busy4, 0);
        m = 0;
        for (int i = 0; i < 16; i++) if (mem4[i] !== s[i]) m++;
        check("small_ram_final", m, 0);
    endtask

    initial begin
        rst_n = 1'b0; commenco = 1'b0; init_en = 1'b0; key = '0; preload = 1'b0;
        commenco4 = 1'b0; init4 = 1'b0; key4 = '0;
        repeat (3) @(negedge clk);
        check("reset_address", addr8, 0);
        check("reset_data", data8, 0);
        check("reset_wen", wen8, 0);
        check("reset_busy", busy8, 0);
        check("reset_finito", fin8, 0);
        check("reset_small_busy", busy4, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run8(1'b1, 24'h000000, -1, -1, 1'b0);
        run8(1'b1, 24'h010203, -1, -1, 1'b0);

        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        run8(1'b0, 24'h1a2b3c, -1, -1, 1'b0);

        run8(1'b1, 24'hdeadbe, 300, -1, 1'b1);
        run8(1'b1, 24'h0f1e2d, -1, -1, 1'b0);

        run8(1'b1, 24'h55aa33, -1, 900, 1'b0);
        run8(1'b1, 24'h55aa33, -1, -1, 1'b0);

        run4(8'hA5);
        run4(8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
